// File: rtl/mlp_train_sequencer.sv
// Training-run sequencer for a small MLP: presents stored samples, strobes weight
// updates, counts epochs and reports the per-epoch summed absolute error.
module mlp_train_sequencer #(
  parameter int NUM_SAMPLES   = 4,
  parameter int NUM_EPOCHS    = 250,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [15:0] cfg_x1,
  input  logic [15:0] cfg_x2,
  input  logic [15:0] cfg_y,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] mlp_y_out,
  output logic        mlp_rst,
  output logic        mlp_train,
  output logic [15:0] mlp_x1,
  output logic [15:0] mlp_x2,
  output logic [15:0] mlp_y_target,
  output logic        busy,
  output logic        done,
  output logic [15:0] epoch_count,
  output logic [1:0]  sample_idx,
  output logic [23:0] err_sum,
  output logic        err_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_TRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0]  LAST_IDX    = 2'(NUM_SAMPLES - 1);
  localparam logic [3:0]  LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
  localparam logic [15:0] EPOCH_LIMIT = 16'(NUM_EPOCHS);

  state_e      state_q, state_d;
  logic [47:0] mem_q [4];
  logic [47:0] mem_d [4];
  logic [3:0]  settle_q, settle_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] epoch_q, epoch_d;
  logic [23:0] acc_q, acc_d;
  logic [23:0] err_sum_q, err_sum_d;
  logic        err_valid_q, err_valid_d;
  logic        done_q, done_d;
  logic [15:0] x1_q, x1_d;
  logic [15:0] x2_q, x2_d;
  logic [15:0] tgt_q, tgt_d;

  logic [15:0] abs_diff;
  logic [24:0] acc_sum;
  logic [23:0] acc_sat;

  assign busy = (state_q == S_INIT) || (state_q == S_LOAD) || (state_q == S_TRAIN);

  // Unsigned 16-bit distance between network output and target, added with saturation.
  assign abs_diff = (mlp_y_out >= tgt_q) ? (mlp_y_out - tgt_q) : (tgt_q - mlp_y_out);
  assign acc_sum  = {1'b0, acc_q} + {9'b0, abs_diff};
  assign acc_sat  = acc_sum[24] ? 24'hFFFFFF : acc_sum[23:0];

  always_comb begin
    mem_d = mem_q;
    if (cfg_we && !busy) begin
      mem_d[cfg_addr] = {cfg_x1, cfg_x2, cfg_y};
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    state_d     = state_q;
    settle_d    = settle_q;
    idx_d       = idx_q;
    epoch_d     = epoch_q;
    acc_d       = acc_q;
    err_sum_d   = err_sum_q;
    err_valid_d = 1'b0;
    done_d      = done_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    tgt_d       = tgt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d = S_INIT;
          done_d  = 1'b0;
          epoch_d = '0;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_INIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          state_d  = S_LOAD;
          idx_d    = '0;
          settle_d = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (settle_q == LAST_SETTLE) begin
          acc_d   = acc_sat;
          state_d = S_TRAIN;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_TRAIN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (idx_q != LAST_IDX) begin
          idx_d    = idx_q + 2'd1;
          settle_d = '0;
          state_d  = S_LOAD;
        end else begin
          err_sum_d   = acc_q;
          err_valid_d = 1'b1;
          acc_d       = '0;
          epoch_d     = epoch_q + 16'd1;
          idx_d       = '0;
          settle_d    = '0;
          if (epoch_q + 16'd1 == EPOCH_LIMIT) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Sample registers are captured only on entry to LOAD so they stay put through TRAIN.
    if (state_d == S_LOAD && state_q != S_LOAD) begin
      {x1_d, x2_d, tgt_d} = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      settle_q    <= '0;
      idx_q       <= '0;
      epoch_q     <= '0;
      acc_q       <= '0;
      err_sum_q   <= '0;
      err_valid_q <= 1'b0;
      done_q      <= 1'b0;
      x1_q        <= '0;
      x2_q        <= '0;
      tgt_q       <= '0;
      // NOTE: the sample store is deliberately reset; it is only four words and must read back zero.
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      idx_q       <= idx_d;
      epoch_q     <= epoch_d;
      acc_q       <= acc_d;
      err_sum_q   <= err_sum_d;
      err_valid_q <= err_valid_d;
      done_q      <= done_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      tgt_q       <= tgt_d;
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign mlp_rst      = (state_q == S_INIT);
  assign mlp_train    = (state_q == S_TRAIN);
  assign mlp_x1       = x1_q;
  assign mlp_x2       = x2_q;
  assign mlp_y_target = tgt_q;
  assign done         = done_q;
  assign epoch_count  = epoch_q;
  assign sample_idx   = idx_q;
  assign err_sum      = err_sum_q;
  assign err_valid    = err_valid_q;

endmodule

// File: tb/tb_mlp_train_sequencer.sv
// Directed bench for mlp_train_sequencer: error-accumulation vector table plus
// hand-written abort, reset, restart and busy-write sequences (2 epochs x 4 samples).
module tb_mlp_train_sequencer;

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, abort;
  logic [1:0]  cfg_addr;
  logic [15:0] cfg_x1, cfg_x2, cfg_y, mlp_y_out;
  logic        mlp_rst, mlp_train, busy, done, err_valid;
  logic [15:0] mlp_x1, mlp_x2, mlp_y_target, epoch_count;
  logic [1:0]  sample_idx;
  logic [23:0] err_sum;

  always #5 clk = ~clk;

  mlp_train_sequencer #(.NUM_SAMPLES(4), .NUM_EPOCHS(2), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_x1(cfg_x1), .cfg_x2(cfg_x2), .cfg_y(cfg_y),
    .start(start), .abort(abort), .mlp_y_out(mlp_y_out),
    .mlp_rst(mlp_rst), .mlp_train(mlp_train),
    .mlp_x1(mlp_x1), .mlp_x2(mlp_x2), .mlp_y_target(mlp_y_target),
    .busy(busy), .done(done), .epoch_count(epoch_count),
    .sample_idx(sample_idx), .err_sum(err_sum), .err_valid(err_valid)
  );

  typedef struct {
    string            name;
    logic [15:0]      y_out;
    logic [3:0][15:0] tgt;
    logic [23:0]      exp_err;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  int n_pass = 0;
  int n_total = 0;

  logic [15:0] exp_x1 [4];
  logic [15:0] exp_y  [4];
  int          n_train, n_rst, n_ev, cyc_done, x_bad;
  logic [23:0] ev_sum [2];
  logic        ab_busy, ab_train;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic write_sample(input logic [1:0] a, input logic [15:0] x1, x2, y);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_x1 = x1; cfg_x2 = x2; cfg_y = y;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic load_vec(input int v);
    mlp_y_out = vecs[v].y_out;
    for (int i = 0; i < 4; i++) begin
      exp_x1[i] = 16'hA000 + 16'(i);
      exp_y[i]  = vecs[v].tgt[i];
      write_sample(2'(i), exp_x1[i], 16'hB000 + 16'(i), exp_y[i]);
    end
  endtask

  // Start a run and watch it for a fixed window; optional abort at the Nth train
  // pulse, an optional cfg_we window and an optional start window (cycle numbers
  // counted from the start-accept edge, c=0).
  task automatic run_monitor(input int abort_at, input int we_lo, input int we_hi,
                             input int st_lo, input int st_hi);
    logic abort_prev;
    n_train = 0; n_rst = 0; n_ev = 0; cyc_done = -1; x_bad = 0;
    ev_sum[0] = '0; ev_sum[1] = '0; ab_busy = 1'b1; ab_train = 1'b1;
    abort_prev = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (abort_prev) begin
        ab_busy  = busy;
        ab_train = mlp_train;
      end
      if (mlp_rst) n_rst++;
      if (mlp_train) begin
        n_train++;
        if (mlp_x1 !== exp_x1[sample_idx] || mlp_y_target !== exp_y[sample_idx]) x_bad++;
      end
      if (err_valid) begin
        if (n_ev < 2) ev_sum[n_ev] = err_sum;
        n_ev++;
      end
      if (done && cyc_done < 0) cyc_done = c;
      cfg_we = (c >= we_lo && c < we_hi);
      start  = (c >= st_lo && c < st_hi);
      abort  = (abort_at > 0 && mlp_train && n_train == abort_at);
      abort_prev = abort;
    end
    cfg_we = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_mlp_rst"},   32'(mlp_rst), 0);
    check({tag, "_mlp_train"}, 32'(mlp_train), 0);
    check({tag, "_err_valid"}, 32'(err_valid), 0);
    check({tag, "_epoch"},     32'(epoch_count), 0);
    check({tag, "_idx"},       32'(sample_idx), 0);
    check({tag, "_err_sum"},   32'(err_sum), 0);
    check({tag, "_x1"},        32'(mlp_x1), 0);
    check({tag, "_x2"},        32'(mlp_x2), 0);
    check({tag, "_ytgt"},      32'(mlp_y_target), 0);
  endtask

  initial begin
    vecs[0] = '{"half_lsb",  16'h0080, {16'h0000, 16'h0100, 16'h0100, 16'h0000}, 24'h000200};
    vecs[1] = '{"tgt_high",  16'h0000, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 24'h03FFFC};
    vecs[2] = '{"out_high",  16'hFFFF, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 24'h03FFFC};
    vecs[3] = '{"exact",     16'h1234, {16'h1234, 16'h1234, 16'h1234, 16'h1234}, 24'h000000};
    vecs[4] = '{"mixed",     16'h0100, {16'h0300, 16'h0050, 16'h0200, 16'h0000}, 24'h0004B0};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_x1 = '0; cfg_x2 = '0; cfg_y = '0;
    start = 1'b0; abort = 1'b0; mlp_y_out = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_outputs("por");

    for (int v = 0; v < NV; v++) begin
      load_vec(v);
      run_monitor(0, 0, 0, 0, 0);
      check({vecs[v].name, "_cycles_to_done"}, 32'(cyc_done), 17);
      check({vecs[v].name, "_train_pulses"},   32'(n_train), 8);
      check({vecs[v].name, "_rst_pulses"},     32'(n_rst), 1);
      check({vecs[v].name, "_err_valid_cnt"},  32'(n_ev), 2);
      check({vecs[v].name, "_err_sum_ep1"},    32'(ev_sum[0]), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_err_sum_ep2"},    32'(ev_sum[1]), 32'(vecs[v].exp_err));
      check({vecs[v].name, "_epoch_count"},    32'(epoch_count), 2);
      check({vecs[v].name, "_sample_bad"},     32'(x_bad), 0);
      check({vecs[v].name, "_busy_end"},       32'(busy), 0);
    end

    // Abort during the third train pulse.
    run_monitor(3, 0, 0, 0, 0);
    check("abort_train_pulses", 32'(n_train), 3);
    check("abort_busy_next",    32'(ab_busy), 0);
    check("abort_train_next",   32'(ab_train), 0);
    check("abort_done",         32'(done), 0);
    check("abort_epoch",        32'(epoch_count), 0);
    check("abort_no_err_valid", 32'(n_ev), 0);
    check("abort_err_sum_held", 32'(err_sum), 32'(vecs[4].exp_err));

    // Start held while busy must not restart the run.
    run_monitor(0, 0, 0, 4, 8);
    check("restart_rst_pulses", 32'(n_rst), 1);
    check("restart_cycles",     32'(cyc_done), 17);
    check("restart_trains",     32'(n_train), 8);

    // Writes while busy are dropped; the same write after done lands.
    cfg_addr = 2'd0; cfg_x1 = 16'hFFFF; cfg_x2 = 16'hB000; cfg_y = exp_y[0];
    run_monitor(0, 1, 10, 0, 0);
    check("busy_write_ignored", 32'(x_bad), 0);
    check("busy_write_cycles",  32'(cyc_done), 17);
    write_sample(2'd0, 16'hFFFF, 16'hB000, exp_y[0]);
    exp_x1[0] = 16'hFFFF;
    run_monitor(0, 0, 0, 0, 0);
    check("idle_write_applied", 32'(x_bad), 0);

    // Synchronous reset in the second LOAD of a run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midrst");

    // start together with abort in IDLE leaves the state alone.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy",    32'(busy), 0);
    check("start_abort_mlp_rst", 32'(mlp_rst), 0);

    load_vec(0);
    run_monitor(0, 0, 0, 0, 0);
    check("after_rst_cycles",  32'(cyc_done), 17);
    check("after_rst_trains",  32'(n_train), 8);
    check("after_rst_err_sum", 32'(ev_sum[1]), 32'h200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
